// File: rtl/ckmon_pkg.sv
// Shared types and constants for the checkbits monitor: FSM state encoding,
// default marker codes and a small saturating-increment helper.
package ckmon_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StWaitStart = 3'd1,
    StWaitPass  = 3'd2,
    StPass      = 3'd3,
    StFail      = 3'd4,
    StTimeout   = 3'd5
  } ckmon_state_e;

  localparam logic [15:0] DefStartCode = 16'hAB60;
  localparam logic [15:0] DefPassCode  = 16'hAB61;
  localparam logic [15:0] DefFailCode  = 16'hAB6F;

  localparam int unsigned HistDepth = 4;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/ckmon_stable_filter.sv
// Registers the checkbits word every cycle and emits a single-cycle accept pulse once the same
// value has been sampled StableCycles times in a row; code_o holds the value being accepted.
module ckmon_stable_filter #(
  parameter int unsigned StableCycles = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] sample_i,
  output logic        accept_o,
  output logic [15:0] code_o
);

  localparam logic [7:0] RunMax = 8'(StableCycles);

  logic [15:0] sample_q;
  logic [7:0]  run_q, run_d;
  logic        accept_q, accept_d;
  logic        same;

  // run_q == 0 only straight out of reset, meaning "no sample taken yet".
  always_comb begin
    same     = (sample_i == sample_q) && (run_q != 8'd0);
    run_d    = 8'd1;
    if (same) begin
      run_d = (run_q >= RunMax) ? RunMax : run_q + 8'd1;
    end
    // Fire on the sample that completes the run, never again while it persists.
    accept_d = (run_d == RunMax) && !(same && (run_q == RunMax));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sample_q <= 16'h0000;
      run_q    <= 8'd0;
      accept_q <= 1'b0;
    end else begin
      sample_q <= sample_i;
      run_q    <= run_d;
      accept_q <= accept_d;
    end
  end

  assign accept_o = accept_q;
  assign code_o   = sample_q;

endmodule

// File: rtl/checkbits_monitor.sv
// Watches the firmware checkbits word for start/pass/fail markers with a watchdog.
// Define CKMON_HISTORY_EN to add a 4-entry FIFO of accepted codes (hist_rd/hist_data/hist_empty).
module checkbits_monitor
  import ckmon_pkg::*;
#(
  parameter logic [15:0] START_CODE     = DefStartCode,
  parameter logic [15:0] PASS_CODE      = DefPassCode,
  parameter logic [15:0] FAIL_CODE      = DefFailCode,
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 75000
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        enable,
  input  logic        clear,
  input  logic [15:0] checkbits,
  output logic [2:0]  state,
  output logic        start_seen,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic        done,
  output logic [15:0] last_code,
  output logic [7:0]  code_count
`ifdef CKMON_HISTORY_EN
  ,
  input  logic        hist_rd,
  output logic [15:0] hist_data,
  output logic        hist_empty
`endif
);

  localparam logic [23:0] TimeoutLimit = 24'(TIMEOUT_CYCLES);

  ckmon_state_e state_q;
  logic [23:0]  wdog_q, wdog_nxt;
  logic         expired;
  logic         start_seen_q, pass_q, fail_q, timeout_q, done_q;
  logic [15:0]  last_code_q;
  logic [7:0]   code_count_q;
  logic         acc;
  logic [15:0]  acc_code;

  ckmon_stable_filter #(
    .StableCycles(STABLE_CYCLES)
  ) u_filter (
    .clk_i   (clock),
    .rst_ni  (resetb),
    .sample_i(checkbits),
    .accept_o(acc),
    .code_o  (acc_code)
  );

  // Saturating so a start marker winning over expiry still times out on the next cycle.
  assign wdog_nxt = (wdog_q == 24'hFF_FFFF) ? wdog_q : wdog_q + 24'd1;
  assign expired  = (wdog_nxt >= TimeoutLimit);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q      <= StIdle;
      wdog_q       <= 24'd0;
      start_seen_q <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      timeout_q    <= 1'b0;
      done_q       <= 1'b0;
      last_code_q  <= 16'h0000;
      code_count_q <= 8'd0;
    end else if (clear || !enable) begin
      state_q   <= StIdle;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q      <= StWaitStart;
          wdog_q       <= 24'd0;
          code_count_q <= 8'd0;
          start_seen_q <= 1'b0;
        end
        StWaitStart, StWaitPass: begin
          wdog_q <= wdog_nxt;
          if (acc) begin
            last_code_q  <= acc_code;
            code_count_q <= sat_inc8(code_count_q);
          end
          // Accepted markers outrank a watchdog expiry in the same cycle.
          if (acc && (state_q == StWaitStart) && (acc_code == START_CODE)) begin
            state_q      <= StWaitPass;
            start_seen_q <= 1'b1;
          end else if (acc && (state_q == StWaitPass) && (acc_code == PASS_CODE)) begin
            state_q <= StPass;
            pass_q  <= 1'b1;
            done_q  <= 1'b1;
          end else if (acc && ((acc_code == PASS_CODE) || (acc_code == FAIL_CODE))) begin
            state_q <= StFail;
            fail_q  <= 1'b1;
            done_q  <= 1'b1;
          end else if (expired) begin
            state_q   <= StTimeout;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
          end
        end
        StPass, StFail, StTimeout: begin
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign state      = state_q;
  assign start_seen = start_seen_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign timeout    = timeout_q;
  assign done       = done_q;
  assign last_code  = last_code_q;
  assign code_count = code_count_q;

`ifdef CKMON_HISTORY_EN
  logic [15:0] hist_mem_q [HistDepth];
  logic [1:0]  hist_rd_ptr_q, hist_wr_ptr_q;
  logic [2:0]  hist_cnt_q;
  logic        hist_push, hist_pop, hist_flush, hist_record;

  assign hist_flush  = clear || (enable && (state_q == StIdle));
  assign hist_record = acc && enable && ((state_q == StWaitStart) || (state_q == StWaitPass));
  // A full FIFO drops the newest code, even if a pop frees a slot this cycle.
  assign hist_push   = hist_record && (hist_cnt_q != 3'(HistDepth));
  assign hist_pop    = hist_rd && (hist_cnt_q != 3'd0);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < HistDepth; i++) begin
        hist_mem_q[i] <= 16'h0000;
      end
      hist_rd_ptr_q <= 2'd0;
      hist_wr_ptr_q <= 2'd0;
      hist_cnt_q    <= 3'd0;
    end else if (hist_flush) begin
      hist_rd_ptr_q <= 2'd0;
      hist_wr_ptr_q <= 2'd0;
      hist_cnt_q    <= 3'd0;
    end else begin
      if (hist_push) begin
        hist_mem_q[hist_wr_ptr_q] <= acc_code;
        hist_wr_ptr_q             <= hist_wr_ptr_q + 2'd1;
      end
      if (hist_pop) begin
        hist_rd_ptr_q <= hist_rd_ptr_q + 2'd1;
      end
      hist_cnt_q <= hist_cnt_q + {2'b00, hist_push} - {2'b00, hist_pop};
    end
  end

  assign hist_data  = hist_mem_q[hist_rd_ptr_q];
  assign hist_empty = (hist_cnt_q == 3'd0);
`endif

endmodule

// File: tb/tb_checkbits_monitor.sv
// Self-checking bench for checkbits_monitor: directed table, hand-written corner sequences and
// randomized stimulus compared every cycle against a behavioural model.
module tb_checkbits_monitor;

  localparam int unsigned Stable = 4;
  localparam int unsigned Tmo    = 100;
  localparam logic [15:0] CStart = 16'hAB60;
  localparam logic [15:0] CPass  = 16'hAB61;
  localparam logic [15:0] CFail  = 16'hAB6F;

  logic        clock = 1'b0;
  logic        resetb, enable, clear;
  logic [15:0] checkbits;
  logic [2:0]  state;
  logic        start_seen, pass, fail, timeout, done;
  logic [15:0] last_code;
  logic [7:0]  code_count;
`ifdef CKMON_HISTORY_EN
  logic        hist_rd;
  logic [15:0] hist_data;
  logic        hist_empty;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  checkbits_monitor #(
    .STABLE_CYCLES (Stable),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clock     (clock),
    .resetb    (resetb),
    .enable    (enable),
    .clear     (clear),
    .checkbits (checkbits),
    .state     (state),
    .start_seen(start_seen),
    .pass      (pass),
    .fail      (fail),
    .timeout   (timeout),
    .done      (done),
    .last_code (last_code),
    .code_count(code_count)
`ifdef CKMON_HISTORY_EN
    ,
    .hist_rd   (hist_rd),
    .hist_data (hist_data),
    .hist_empty(hist_empty)
`endif
  );

  // Behavioural model: run length of identical samples, accept decided one edge before use.
  logic [15:0] m_prev, m_acc_code, m_last;
  int          m_run, m_state, m_wd, m_count;
  bit          m_acc, m_start;

  task automatic model_reset();
    m_prev = 16'h0; m_acc_code = 16'h0; m_last = 16'h0;
    m_run = 0; m_state = 0; m_wd = 0; m_count = 0; m_acc = 0; m_start = 0;
  endtask

  task automatic model_step();
    bit          acc;
    logic [15:0] ac;
    acc = m_acc;
    ac  = m_acc_code;
    if (m_run > 0 && checkbits == m_prev) m_run++;
    else m_run = 1;
    m_prev     = checkbits;
    m_acc      = (m_run == Stable);
    m_acc_code = checkbits;
    if (clear || !enable) begin
      m_state = 0;
    end else if (m_state == 0) begin
      m_state = 1; m_wd = 0; m_count = 0; m_start = 0;
    end else if (m_state == 1 || m_state == 2) begin
      m_wd++;
      if (acc) begin
        m_last = ac;
        if (m_count < 255) m_count++;
      end
      if (acc && m_state == 1 && ac == CStart) begin
        m_state = 2; m_start = 1;
      end else if (acc && ac == CPass) m_state = (m_state == 1) ? 4 : 3;
      else if (acc && ac == CFail) m_state = 4;
      else if (m_wd >= Tmo) m_state = 5;
    end
  endtask

  function automatic logic [31:0] act_vec();
    return {state, start_seen, pass, fail, timeout, done, last_code, code_count};
  endfunction

  function automatic logic [31:0] exp_vec();
    return {3'(m_state), m_start, (m_state == 3), (m_state == 4), (m_state == 5), (m_state >= 3),
            m_last, 8'(m_count)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      model_step();
      @(negedge clock);
      check("model", act_vec(), exp_vec());
    end
  endtask

  // Settle checkbits at 0000 while idle, then arm; returns just after the arming edge.
  task automatic rearm();
    enable = 1'b0; clear = 1'b0; checkbits = 16'h0000;
    tick(6);
    enable = 1'b1;
    tick(1);
  endtask

  typedef struct {
    bit          rearm;
    logic [15:0] code;
    int          hold;
    logic [2:0]  st;
    bit          ss;
    logic [7:0]  cnt;
    logic [15:0] last;
  } vec_t;

  vec_t        vecs[9];
  int          left, hold, pick;
  logic [15:0] val;

  initial begin
    vecs[0] = '{1'b1, 16'hAB60, 10, 3'd2, 1'b1, 8'd1, 16'hAB60};
    vecs[1] = '{1'b0, 16'hAB61, 10, 3'd3, 1'b1, 8'd2, 16'hAB61};
    vecs[2] = '{1'b1, 16'hAB60, 3,  3'd1, 1'b0, 8'd0, 16'hAB61};
    vecs[3] = '{1'b0, 16'h0000, 3,  3'd1, 1'b0, 8'd0, 16'hAB61};
    vecs[4] = '{1'b1, 16'hAB61, 8,  3'd4, 1'b0, 8'd1, 16'hAB61};
    vecs[5] = '{1'b1, 16'h1234, 6,  3'd1, 1'b0, 8'd1, 16'h1234};
    vecs[6] = '{1'b0, 16'hAB60, 6,  3'd2, 1'b1, 8'd2, 16'hAB60};
    vecs[7] = '{1'b0, 16'h5555, 6,  3'd2, 1'b1, 8'd3, 16'h5555};
    vecs[8] = '{1'b0, 16'hAB6F, 6,  3'd4, 1'b1, 8'd4, 16'hAB6F};

    resetb = 1'b0; enable = 1'b0; clear = 1'b0; checkbits = 16'h0000;
`ifdef CKMON_HISTORY_EN
    hist_rd = 1'b0;
`endif
    model_reset();
    repeat (2) @(negedge clock);
    check("reset outputs", act_vec(), 32'h0);
    resetb = 1'b1;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].rearm) rearm();
      checkbits = vecs[i].code;
      tick(vecs[i].hold);
      check($sformatf("row%0d state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("row%0d start_seen", i), 32'(start_seen), 32'(vecs[i].ss));
      check($sformatf("row%0d code_count", i), 32'(code_count), 32'(vecs[i].cnt));
      check($sformatf("row%0d last_code", i), 32'(last_code), 32'(vecs[i].last));
      check($sformatf("row%0d flags", i), {28'h0, pass, fail, timeout, done},
            {28'h0, vecs[i].st == 3'd3, vecs[i].st == 3'd4, vecs[i].st == 3'd5, vecs[i].st >= 3'd3});
    end

    // Latency: the sample register holds AB60 after the first edge; start_seen four edges later.
    rearm();
    checkbits = CStart;
    tick(4);
    check("latency start_seen early", 32'(start_seen), 32'd0);
    tick(1);
    check("latency start_seen", 32'(start_seen), 32'd1);
    checkbits = CPass;
    tick(5);
    check("seq pass", {29'h0, pass, done, 1'b0}, {29'h0, 1'b1, 1'b1, 1'b0});
    check("seq count", 32'(code_count), 32'd2);

    // Watchdog with no codes: expires exactly Tmo edges after WAIT_START entry
    rearm();
    tick(Tmo - 1);
    check("timeout early", {29'h0, state}, 32'd1);
    tick(1);
    check("timeout state", {29'h0, state}, 32'd5);
    check("timeout flags", {30'h0, timeout, done}, 32'd3);

    // Pass accepted on the same edge the watchdog expires
    rearm();
    checkbits = CStart;
    tick(95);
    check("coincide wait_pass", {29'h0, state}, 32'd2);
    checkbits = CPass;
    tick(4);
    check("coincide pre", {29'h0, state}, 32'd2);
    tick(1);
    check("coincide pass", {29'h0, pass, timeout, 1'b0}, {29'h0, 1'b1, 1'b0, 1'b0});

    // One cycle later the watchdog wins
    rearm();
    checkbits = CStart;
    tick(96);
    checkbits = CPass;
    tick(4);
    check("late pass timeout", {29'h0, state}, 32'd5);

    // Asynchronous reset mid-run
    rearm();
    checkbits = CStart;
    tick(6);
    check("pre-reset state", {29'h0, state}, 32'd2);
    #2;
    resetb = 1'b0;
    model_reset();
    #1;
    check("async reset outputs", act_vec(), 32'h0);
    @(negedge clock);
    check("held reset outputs", act_vec(), 32'h0);
    enable = 1'b0; checkbits = 16'h0000;
    resetb = 1'b1;
    rearm();
    check("rearm after reset", {state, start_seen, code_count}, {3'd1, 1'b0, 8'd0});

`ifdef CKMON_HISTORY_EN
    rearm();
    check("hist empty after arm", 32'(hist_empty), 32'd1);
    for (int i = 0; i < 5; i++) begin
      val = 16'h1111 * 16'(i + 1);
      checkbits = val;
      tick(6);
    end
    check("hist code_count", 32'(code_count), 32'd5);
    for (int i = 0; i < 4; i++) begin
      val = 16'h1111 * 16'(i + 1);
      check($sformatf("hist pop%0d empty", i), 32'(hist_empty), 32'd0);
      check($sformatf("hist pop%0d data", i), 32'(hist_data), 32'(val));
      hist_rd = 1'b1;
      tick(1);
      hist_rd = 1'b0;
    end
    check("hist drained", 32'(hist_empty), 32'd1);
    hist_rd = 1'b1;
    tick(1);
    hist_rd = 1'b0;
    check("hist pop when empty", 32'(hist_empty), 32'd1);
`endif

    // Randomized runs against the model
    for (int r = 0; r < 30; r++) begin
      rearm();
      left = 110;
      while (left > 0) begin
        pick = $urandom_range(0, 9);
        if (pick <= 2) val = CStart;
        else if (pick <= 4) val = CPass;
        else if (pick == 5) val = CFail;
        else if (pick == 6) val = 16'h0000;
        else val = 16'($urandom);
        hold = $urandom_range(1, 7);
        checkbits = val;
        for (int h = 0; h < hold && left > 0; h++) begin
          clear  = ($urandom_range(0, 49) == 0);
          enable = ($urandom_range(0, 59) != 0);
          tick(1);
          left--;
        end
      end
      clear = 1'b0; enable = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/checkbits_monitor.md
CHECKBITS_MONITOR -- requirements
Module: checkbits_monitor

Interface
REQ-001 SHALL have parameter START_CODE, default 16'hAB60: marker announcing test start.
REQ-002 SHALL have parameter PASS_CODE, default 16'hAB61: marker announcing test pass.
REQ-003 SHALL have parameter FAIL_CODE, default 16'hAB6F: marker announcing firmware-detected failure.
REQ-004 SHALL have parameter STABLE_CYCLES, default 4, legal range 1..255: consecutive identical samples needed to accept a code.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 75000, legal range 1..2^24-1: watchdog limit in clock cycles.
REQ-006 SHALL have port clock, input, 1: sole clock.
REQ-007 SHALL have port resetb, input, 1: reset, asynchronous assert, active-low.
REQ-008 SHALL have port enable, input, 1: arms the monitor while high.
REQ-009 SHALL have port clear, input, 1: synchronous return to IDLE.
REQ-010 SHALL have port checkbits, input, 16: status word from mprj_io[31:16].
REQ-011 SHALL have port state, output, 3: current FSM state encoding.
REQ-012 SHALL have ports start_seen, pass, fail, timeout, done, output, 1 each: status flags.
REQ-013 SHALL have port last_code, output, 16: most recently accepted code.
REQ-014 SHALL have port code_count, output, 8: number of accepted codes since arming, saturating at 255.

Function
REQ-015 SHALL register checkbits every cycle and accept a code with a one-cycle pulse once it has been sampled identically STABLE_CYCLES consecutive times, at most one pulse per stable run.
REQ-016 SHALL give acceptance latency of exactly STABLE_CYCLES cycles from the first cycle the new value is present.
REQ-017 SHALL implement states IDLE=0, WAIT_START=1, WAIT_PASS=2, PASS=3, FAIL=4, TIMEOUT=5.
REQ-018 SHALL go IDLE->WAIT_START when enable=1, clearing the watchdog, code_count and flags.
REQ-019 SHALL go WAIT_START->WAIT_PASS on accepted START_CODE and set start_seen.
REQ-020 SHALL go WAIT_START->FAIL on accepted PASS_CODE or FAIL_CODE (out of order).
REQ-021 SHALL go WAIT_PASS->PASS on accepted PASS_CODE, WAIT_PASS->FAIL on accepted FAIL_CODE, and ignore any other accepted code except to update last_code and code_count.
REQ-022 SHALL count cycles in WAIT_START and WAIT_PASS and enter TIMEOUT when the count reaches TIMEOUT_CYCLES.
REQ-023 SHALL let an accepted code take priority over a timeout occurring in the same cycle.
REQ-024 SHALL hold PASS, FAIL and TIMEOUT until clear=1 or enable=0, with done=1 in all three.
REQ-025 SHALL return to IDLE on enable=0 from any state; clear has priority over all other events.
REQ-026 SHALL derive pass, fail and timeout as registered outputs that are high only in the matching state.

Reset
REQ-027 SHALL on resetb=0 force state=IDLE, all flags 0, last_code=16'h0000, code_count=0, the watchdog counter and filter to 0, and the filter sample register to 16'h0000.
REQ-028 SHALL abort any sequence in progress when reset is asserted mid-run, and treat the first enable after release as a fresh arm.

Configuration
REQ-029 SHALL, with CKMON_HISTORY_EN defined, add ports hist_rd (input, 1), hist_data (output, 16) and hist_empty (output, 1), plus a 4-entry FIFO of accepted codes.
REQ-030 SHALL, in that FIFO, drop the newest code when full, pop on hist_rd when not empty, ignore hist_rd when empty, and flush on arm or clear.
REQ-031 SHALL, without CKMON_HISTORY_EN, omit those ports and the FIFO entirely, with otherwise identical behaviour.

Structure
REQ-032 SHALL place the state typedef and encodings, plus default code constants, in shared package ckmon_pkg.
REQ-033 SHALL implement the stability filter (REQ-015/016) as sub-module ckmon_stable_filter.

Verification
REQ-034 SHALL cover: enable, hold AB60 for 10 cycles, then AB61 for 10 cycles -> start_seen 4 cycles after AB60 appears, pass=1, done=1, code_count=2.
REQ-035 SHALL cover: AB60 glitch for 3 cycles, then 0000 -> no acceptance, state stays WAIT_START.
REQ-036 SHALL cover: enable with TIMEOUT_CYCLES=100 and no codes -> timeout=1 exactly 100 cycles after WAIT_START entry.
REQ-037 SHALL cover: AB61 accepted before AB60 -> fail=1, last_code=AB61.
REQ-038 SHALL cover: AB61 accepted in the same cycle the watchdog expires -> pass=1, timeout=0.
REQ-039 SHALL cover: resetb pulsed low in WAIT_PASS -> all outputs reach reset values immediately; with CKMON_HISTORY_EN, 5 codes accepted -> 4 popped in order, then hist_empty=1.
